vga_layer_compositor: RTL and testbench
=======================================

// Module: vga_layer_compositor
// PURPOSE
//  Parametrised successor of the single-screen draw top. Owns the VGA raster
//  timing counters and drives pix_x/pix_y to N_LAYERS drawer blocks (strings,
//  field, next-piece, ...). Merges their colour/enable outputs by fixed priority,
//  compensates drawer latency on sync/de, and adds run-time test modes.
// PARAMETERS
//  PIX_WIDTH   12    width of pixel counters and pix_x/pix_y
//  N_LAYERS    2     number of drawer inputs; index 0 = highest priority
//  LAYER_LAT   1     drawer latency in clk_vga_i cycles (pix_x in -> data out), >=0
//  H_DISP/H_FPORCH/H_SYNC/H_BPORCH  1280/48/112/248  horizontal timing, pixels
//  V_DISP/V_FPORCH/V_SYNC/V_BPORCH  1024/1/3/38      vertical timing, lines
//  HS_POL/VS_POL  1'b0   active level of hsync/vsync
// PORTS
//  clk_vga_i      in   1             pixel clock
//  rst_i          in   1             synchronous reset, active-high
//  mode_i         in   2             0 normal, 1 colour bars, 2 solid bg, 3 = normal
//  bg_color_i     in   24            {R,G,B} background / solid colour
//  layer_data_i   in   N_LAYERS*24   per-layer {R,G,B}, layer k at [24k+:24]
//  layer_en_i     in   N_LAYERS      per-layer pixel valid
//  pix_x_o        out  PIX_WIDTH     current h counter, to drawers
//  pix_y_o        out  PIX_WIDTH     current v counter, to drawers
//  frame_start_o  out  1             1-cycle pulse at h=0,v=0
//  frame_cnt_o    out  16            frames since reset, wraps 0xFFFF->0
//  vga_hs_o       out  1             hsync, aligned to RGB
//  vga_vs_o       out  1             vsync, aligned to RGB
//  vga_de_o       out  1             data enable, aligned to RGB
//  vga_r_o/g_o/b_o out 8 each        pixel colour
// BEHAVIOUR
//  - H_TOT=H_DISP+H_FPORCH+H_SYNC+H_BPORCH; V_TOT likewise. h counts 0..H_TOT-1,
//    wraps to 0 and increments v; v wraps 0 after V_TOT-1.
//  - de_raw = h<H_DISP && v<V_DISP. hs active for h in [H_DISP+H_FPORCH,
//    +H_SYNC); vs active for v in [V_DISP+V_FPORCH, +V_SYNC). Inactive = ~POL.
//  - pix_x_o=h, pix_y_o=v straight from counter registers (no comb logic).
//  - Layer inputs at cycle t+LAYER_LAT belong to pixel emitted at cycle t.
//  - Mixer: first k (lowest index) with layer_en_i[k] wins, else bg_color_i.
//  - mode_q latched from mode_i only on the frame_start_o cycle; mid-frame
//    changes take effect next frame. Mode 1: 8 vertical bars, bar=x*8/H_DISP
//    (x carried down delay line), colours in order white,yellow,cyan,green,
//    magenta,red,blue,black. Mode 2: bg_color_i everywhere in display area.
//  - RGB output registered: pixel (x,y) appears at t+LAYER_LAT+1. hs/vs/de
//    pass through a LAYER_LAT+1 deep shift register, exact alignment with RGB.
//  - RGB forced to 0 whenever delayed de is 0.
//  - frame_cnt_o increments on the frame_start_o cycle (first pulse after
//    reset leaves it at 1).
//  - Reset (any cycle, incl. mid-frame): h=v=0, mode_q=0, frame_cnt_o=0,
//    delay line flushed to hs=~HS_POL, vs=~VS_POL, de=0; RGB=0. First cycle
//    after rst_i falls is pixel (0,0) with frame_start_o=1.
// STRUCTURE
//  - Shared package vga_pkg: rgb_t (24-bit packed), vga_mode_t enum,
//    COLOR_BAR lookup constants, timing-parameter struct for standard modes.
//  - One sub-module: vga_raster_counter (h/v counters, hs/vs/de_raw,
//    frame_start). Mixer, mode logic and delay line live in the top.
// TESTING  (small timing: H 8/2/2/2 -> H_TOT 14, V 4/1/1/1 -> V_TOT 7, LAYER_LAT 2)
//  - Reset then run 2 frames -> frame_start every 98 cycles, hs low for h=10..11,
//    vs low for v=5, vga_de_o high 32 cycles/frame, delayed exactly 3 cycles.
//  - N_LAYERS=2, en0=en1=1, data0=0xFF0000, data1=0x00FF00 -> RGB 0xFF0000;
//    en0=0 -> 0x00FF00; both 0 -> bg_color_i=0x102030.
//  - mode_i=1 changed mid-frame -> current frame unchanged, next frame x=0 gives
//    0xFFFFFF, x=7 gives 0x000000; mode 2 -> all active pixels = bg_color_i.
//  - Layer drives 0xFFFFFF during blanking -> RGB=0 whenever vga_de_o=0.
//  - rst_i pulsed at h=5,v=2 -> next cycle pix_x=pix_y=0, frame_start=1,
//    outputs inactive for 3 cycles, frame_cnt_o=1 after restart.
//  - LAYER_LAT=0 build, layer data tied to pix_x -> RGB(x) matches x of de edge.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA layer compositor and its raster counter.
package vga_pkg;

    localparam int unsigned N_BARS = 8;
    localparam int unsigned BAR_W  = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        MODE_NORMAL     = 2'd0,
        MODE_BARS       = 2'd1,
        MODE_SOLID      = 2'd2,
        MODE_NORMAL_ALT = 2'd3
    } vga_mode_t;

    typedef struct packed {
        int unsigned h_disp;
        int unsigned h_fporch;
        int unsigned h_sync;
        int unsigned h_bporch;
        int unsigned v_disp;
        int unsigned v_fporch;
        int unsigned v_sync;
        int unsigned v_bporch;
    } vga_timing_t;

    // 1280x1024 @ 60 Hz
    localparam vga_timing_t TIMING_SXGA60 = '{
        h_disp: 1280, h_fporch: 48, h_sync: 112, h_bporch: 248,
        v_disp: 1024, v_fporch: 1,  v_sync: 3,   v_bporch: 38
    };

    localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
    localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
    localparam rgb_t BAR_CYAN    = 24'h00FFFF;
    localparam rgb_t BAR_GREEN   = 24'h00FF00;
    localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
    localparam rgb_t BAR_RED     = 24'hFF0000;
    localparam rgb_t BAR_BLUE    = 24'h0000FF;
    localparam rgb_t BAR_BLACK   = 24'h000000;

    function automatic rgb_t color_bar(input logic [BAR_W-1:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_layer_compositor_if.sv
// Drawer bus: raster position out to the drawers, per-layer colour/valid back.
interface vga_layer_compositor_if #(
    parameter int unsigned PIX_WIDTH = 12,
    parameter int unsigned N_LAYERS  = 2
);
    logic [PIX_WIDTH-1:0]   pix_x;
    logic [PIX_WIDTH-1:0]   pix_y;
    logic [N_LAYERS*24-1:0] layer_data;
    logic [N_LAYERS-1:0]    layer_en;

    modport master (output pix_x, output pix_y, input layer_data, input layer_en);
    modport slave  (input pix_x, input pix_y, output layer_data, output layer_en);
endinterface

// File: rtl/vga_raster_counter.sv
// Horizontal/vertical raster counters with registered sync, display-enable and frame-start.
module vga_raster_counter
    import vga_pkg::*;
#(
    parameter int unsigned PIX_WIDTH = 12,
    parameter int unsigned H_DISP    = TIMING_SXGA60.h_disp,
    parameter int unsigned H_FPORCH  = TIMING_SXGA60.h_fporch,
    parameter int unsigned H_SYNC    = TIMING_SXGA60.h_sync,
    parameter int unsigned H_BPORCH  = TIMING_SXGA60.h_bporch,
    parameter int unsigned V_DISP    = TIMING_SXGA60.v_disp,
    parameter int unsigned V_FPORCH  = TIMING_SXGA60.v_fporch,
    parameter int unsigned V_SYNC    = TIMING_SXGA60.v_sync,
    parameter int unsigned V_BPORCH  = TIMING_SXGA60.v_bporch,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [PIX_WIDTH-1:0] h,
    output logic [PIX_WIDTH-1:0] v,
    output logic                 hs,
    output logic                 vs,
    output logic                 de,
    output logic                 frame_start
);
    localparam int unsigned H_TOT = H_DISP + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int unsigned V_TOT = V_DISP + V_FPORCH + V_SYNC + V_BPORCH;

    localparam logic [PIX_WIDTH-1:0] H_LAST   = PIX_WIDTH'(H_TOT - 1);
    localparam logic [PIX_WIDTH-1:0] V_LAST   = PIX_WIDTH'(V_TOT - 1);
    localparam logic [PIX_WIDTH-1:0] H_ACTIVE = PIX_WIDTH'(H_DISP);
    localparam logic [PIX_WIDTH-1:0] V_ACTIVE = PIX_WIDTH'(V_DISP);
    localparam logic [PIX_WIDTH-1:0] HS_BEG   = PIX_WIDTH'(H_DISP + H_FPORCH);
    localparam logic [PIX_WIDTH-1:0] HS_END   = PIX_WIDTH'(H_DISP + H_FPORCH + H_SYNC);
    localparam logic [PIX_WIDTH-1:0] VS_BEG   = PIX_WIDTH'(V_DISP + V_FPORCH);
    localparam logic [PIX_WIDTH-1:0] VS_END   = PIX_WIDTH'(V_DISP + V_FPORCH + V_SYNC);

    logic [PIX_WIDTH-1:0] h_nxt_c;
    logic [PIX_WIDTH-1:0] v_nxt_c;

    always_comb begin
        h_nxt_c = h + PIX_WIDTH'(1);
        v_nxt_c = v;
        if (h == H_LAST) begin
            h_nxt_c = '0;
            v_nxt_c = (v == V_LAST) ? '0 : v + PIX_WIDTH'(1);
        end
    end

    // Decodes are computed from the next position so they stay aligned with h/v.
    always_ff @(posedge clk) begin
        if (rst) begin
            h           <= '0;
            v           <= '0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            h           <= h_nxt_c;
            v           <= v_nxt_c;
            hs          <= (h_nxt_c >= HS_BEG && h_nxt_c < HS_END) ? HS_POL : ~HS_POL;
            vs          <= (v_nxt_c >= VS_BEG && v_nxt_c < VS_END) ? VS_POL : ~VS_POL;
            de          <= (h_nxt_c < H_ACTIVE) && (v_nxt_c < V_ACTIVE);
            frame_start <= (h_nxt_c == '0) && (v_nxt_c == '0);
        end
    end

endmodule

// File: rtl/vga_layer_compositor.sv
// VGA raster owner: drives drawer layers, merges them by priority, aligns sync with RGB.
module vga_layer_compositor
    import vga_pkg::*;
#(
    parameter int unsigned PIX_WIDTH = 12,
    parameter int unsigned N_LAYERS  = 2,
    parameter int unsigned LAYER_LAT = 1,
    parameter int unsigned H_DISP    = TIMING_SXGA60.h_disp,
    parameter int unsigned H_FPORCH  = TIMING_SXGA60.h_fporch,
    parameter int unsigned H_SYNC    = TIMING_SXGA60.h_sync,
    parameter int unsigned H_BPORCH  = TIMING_SXGA60.h_bporch,
    parameter int unsigned V_DISP    = TIMING_SXGA60.v_disp,
    parameter int unsigned V_FPORCH  = TIMING_SXGA60.v_fporch,
    parameter int unsigned V_SYNC    = TIMING_SXGA60.v_sync,
    parameter int unsigned V_BPORCH  = TIMING_SXGA60.v_bporch,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0
) (
    input  logic                   clk_vga_i,
    input  logic                   rst_i,
    input  logic [1:0]             mode_i,
    input  logic [23:0]            bg_color_i,
    vga_layer_compositor_if.master drw,
    output logic                   frame_start_o,
    output logic [15:0]            frame_cnt_o,
    output logic                   vga_hs_o,
    output logic                   vga_vs_o,
    output logic                   vga_de_o,
    output logic [7:0]             vga_r_o,
    output logic [7:0]             vga_g_o,
    output logic [7:0]             vga_b_o
);
    localparam int unsigned DEPTH = LAYER_LAT + 1;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned RGB_W = 24;

    // One raster position travelling down the latency-compensation line.
    typedef struct packed {
        logic [PIX_WIDTH-1:0] x;
        vga_mode_t            mode;
        logic                 hs;
        logic                 vs;
        logic                 de;
    } pipe_t;

    localparam pipe_t FLUSH = '{x: '0, mode: MODE_NORMAL, hs: ~HS_POL, vs: ~VS_POL, de: 1'b0};

    logic             raw_hs;
    logic             raw_vs;
    logic             raw_de;
    pipe_t            raw_c;
    pipe_t            tap_c;
    pipe_t            pipe_q [1:DEPTH];
    vga_mode_t        mode_q;
    rgb_t             layer_c;
    rgb_t             mix_c;
    rgb_t             rgb_q;
    logic [BAR_W-1:0] bar_c;
    logic [CNT_W-1:0] frame_cnt_q;

    vga_raster_counter #(
        .PIX_WIDTH (PIX_WIDTH),
        .H_DISP    (H_DISP),
        .H_FPORCH  (H_FPORCH),
        .H_SYNC    (H_SYNC),
        .H_BPORCH  (H_BPORCH),
        .V_DISP    (V_DISP),
        .V_FPORCH  (V_FPORCH),
        .V_SYNC    (V_SYNC),
        .V_BPORCH  (V_BPORCH),
        .HS_POL    (HS_POL),
        .VS_POL    (VS_POL)
    ) u_raster (
        .clk         (clk_vga_i),
        .rst         (rst_i),
        .h           (drw.pix_x),
        .v           (drw.pix_y),
        .hs          (raw_hs),
        .vs          (raw_vs),
        .de          (raw_de),
        .frame_start (frame_start_o)
    );

    // The frame-start pixel already uses the newly latched mode.
    always_comb begin
        raw_c      = FLUSH;
        raw_c.x    = drw.pix_x;
        raw_c.mode = frame_start_o ? vga_mode_t'(mode_i) : mode_q;
        raw_c.hs   = raw_hs;
        raw_c.vs   = raw_vs;
        raw_c.de   = raw_de;
    end

    generate
        if (LAYER_LAT == 0) begin : g_tap_direct
            assign tap_c = raw_c;
        end else begin : g_tap_pipe
            assign tap_c = pipe_q[LAYER_LAT];
        end
    endgenerate

    // Lowest-index enabled layer wins; test modes override the layers.
    always_comb begin
        layer_c = rgb_t'(bg_color_i);
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (drw.layer_en[k]) begin
                layer_c = rgb_t'(drw.layer_data[RGB_W*k +: RGB_W]);
            end
        end
        bar_c = BAR_W'((32'(tap_c.x) * N_BARS) / H_DISP);
        case (tap_c.mode)
            MODE_BARS:  mix_c = color_bar(bar_c);
            MODE_SOLID: mix_c = rgb_t'(bg_color_i);
            default:    mix_c = layer_c;
        endcase
    end

    always_ff @(posedge clk_vga_i) begin
        if (rst_i) begin
            for (int unsigned i = 1; i <= DEPTH; i++) begin
                pipe_q[i] <= FLUSH;
            end
            rgb_q       <= '0;
            mode_q      <= MODE_NORMAL;
            frame_cnt_q <= '0;
        end else begin
            pipe_q[1] <= raw_c;
            for (int unsigned i = 2; i <= DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            rgb_q <= tap_c.de ? mix_c : rgb_t'('0);
            if (frame_start_o) begin
                mode_q      <= raw_c.mode;
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
        end
    end

    assign vga_hs_o    = pipe_q[DEPTH].hs;
    assign vga_vs_o    = pipe_q[DEPTH].vs;
    assign vga_de_o    = pipe_q[DEPTH].de;
    assign vga_r_o     = rgb_q.r;
    assign vga_g_o     = rgb_q.g;
    assign vga_b_o     = rgb_q.b;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Scoreboard bench for vga_layer_compositor on a tiny 14x7 raster (latency 2 and latency 0 builds).
module tb_vga_layer_compositor;

    localparam int unsigned PW     = 12;
    localparam int unsigned H_DISP = 8;
    localparam int unsigned V_DISP = 4;
    localparam int unsigned H_TOT  = 14;
    localparam int unsigned V_TOT  = 7;
    localparam int unsigned HS_LO  = 10;
    localparam int unsigned HS_HI  = 11;
    localparam int unsigned VS_LN  = 5;

    localparam int P_BOTH = 0;
    localparam int P_L1   = 1;
    localparam int P_NONE = 2;
    localparam int P_RAND = 3;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } exp_t;

    typedef struct packed {
        logic [1:0]  en;
        logic [47:0] data;
    } drw_t;

    localparam exp_t INACT = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 24'h0};
    localparam drw_t IDLE  = '{en: 2'b00, data: 48'h0};

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [23:0] bg;
    logic        frame_start, frame_start0;
    logic [15:0] frame_cnt, frame_cnt0;
    logic        hs, vs, de, hs0, vs0, de0;
    logic [7:0]  r, g, b, r0, g0, b0;

    always #5 clk = ~clk;

    vga_layer_compositor_if #(.PIX_WIDTH(PW), .N_LAYERS(2)) drw ();
    vga_layer_compositor_if #(.PIX_WIDTH(PW), .N_LAYERS(1)) drw0 ();

    assign drw0.layer_data = {drw0.pix_x[7:0], drw0.pix_x[7:0], drw0.pix_x[7:0]};
    assign drw0.layer_en   = 1'b1;

    vga_layer_compositor #(
        .PIX_WIDTH(PW), .N_LAYERS(2), .LAYER_LAT(2),
        .H_DISP(8), .H_FPORCH(2), .H_SYNC(2), .H_BPORCH(2),
        .V_DISP(4), .V_FPORCH(1), .V_SYNC(1), .V_BPORCH(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut (
        .clk_vga_i(clk), .rst_i(rst), .mode_i(mode), .bg_color_i(bg), .drw(drw),
        .frame_start_o(frame_start), .frame_cnt_o(frame_cnt),
        .vga_hs_o(hs), .vga_vs_o(vs), .vga_de_o(de),
        .vga_r_o(r), .vga_g_o(g), .vga_b_o(b)
    );

    vga_layer_compositor #(
        .PIX_WIDTH(PW), .N_LAYERS(1), .LAYER_LAT(0),
        .H_DISP(8), .H_FPORCH(2), .H_SYNC(2), .H_BPORCH(2),
        .V_DISP(4), .V_FPORCH(1), .V_SYNC(1), .V_BPORCH(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut_lat0 (
        .clk_vga_i(clk), .rst_i(rst), .mode_i(2'd0), .bg_color_i(24'h0), .drw(drw0),
        .frame_start_o(frame_start0), .frame_cnt_o(frame_cnt0),
        .vga_hs_o(hs0), .vga_vs_o(vs0), .vga_de_o(de0),
        .vga_r_o(r0), .vga_g_o(g0), .vga_b_o(b0)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned de_cnt   = 0;

    exp_t exp_q  [$];
    exp_t exp0_q [$];
    drw_t drw_q  [$];

    int unsigned m_h = 0, m_v = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [15:0] m_fcnt = 16'd0;
    logic        rst_req;
    logic [1:0]  mode_val;
    int          pat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [23:0] bar_ref(input int unsigned idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] mix_ref(input drw_t d);
        if (d.en[0]) return d.data[23:0];
        if (d.en[1]) return d.data[47:24];
        return bg;
    endfunction

    function automatic drw_t make_drawer(input logic active);
        drw_t d;
        d.en   = 2'b11;
        d.data = {24'h00FF00, 24'hFF0000};
        if (!active) begin
            d.data = {24'hFFFFFF, 24'hFFFFFF};
        end else begin
            case (pat)
                P_L1:    d.en = 2'b10;
                P_NONE:  d.en = 2'b00;
                P_RAND:  begin
                    d.en   = 2'($urandom_range(0, 3));
                    d.data = {24'($urandom), 24'($urandom)};
                end
                default: d.en = 2'b11;
            endcase
        end
        return d;
    endfunction

    // One pixel clock: check outputs, drive drawer data, advance the reference raster.
    task automatic step();
        exp_t        e;
        drw_t        d;
        drw_t        cur;
        logic        fs_m;
        logic        de_m;
        logic [1:0]  cur_mode;
        logic [23:0] want;
        @(negedge clk);
        check_eq("pix_x", 32'(drw.pix_x), 32'(m_h));
        check_eq("pix_y", 32'(drw.pix_y), 32'(m_v));
        check_eq("frame_start", 32'(frame_start), 32'(m_h == 0 && m_v == 0));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        check_eq("lat0_pix_x", 32'(drw0.pix_x), 32'(m_h));
        check_eq("lat0_frame_start", 32'(frame_start0), 32'(m_h == 0 && m_v == 0));
        check_eq("lat0_frame_cnt", 32'(frame_cnt0), 32'(m_fcnt));
        de_cnt += 32'(de);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("hs", 32'(hs), 32'(e.hs));
            check_eq("vs", 32'(vs), 32'(e.vs));
            check_eq("de", 32'(de), 32'(e.de));
            check_eq("rgb", 32'({r, g, b}), 32'(e.rgb));
        end
        if (exp0_q.size() > 0) begin
            e = exp0_q.pop_front();
            check_eq("lat0_hs", 32'(hs0), 32'(e.hs));
            check_eq("lat0_vs", 32'(vs0), 32'(e.vs));
            check_eq("lat0_de", 32'(de0), 32'(e.de));
            check_eq("lat0_rgb", 32'({r0, g0, b0}), 32'(e.rgb));
        end
        d = (drw_q.size() > 0) ? drw_q.pop_front() : IDLE;
        drw.layer_en   = d.en;
        drw.layer_data = d.data;
        rst  = rst_req;
        mode = mode_val;
        if (rst_req) begin
            exp_q.delete();
            repeat (3) exp_q.push_back(INACT);
            exp0_q.delete();
            exp0_q.push_back(INACT);
            drw_q.delete();
            repeat (2) drw_q.push_back(IDLE);
            m_h    = 0;
            m_v    = 0;
            m_mode = 2'd0;
            m_fcnt = 16'd0;
        end else begin
            fs_m     = (m_h == 0 && m_v == 0);
            cur_mode = fs_m ? mode_val : m_mode;
            if (fs_m) begin
                m_mode = cur_mode;
                m_fcnt = m_fcnt + 16'd1;
            end
            de_m = (m_h < H_DISP) && (m_v < V_DISP);
            cur  = make_drawer(de_m);
            drw_q.push_back(cur);
            case (cur_mode)
                2'd1:    want = bar_ref(m_h);
                2'd2:    want = bg;
                default: want = mix_ref(cur);
            endcase
            e.hs  = !(m_h >= HS_LO && m_h <= HS_HI);
            e.vs  = !(m_v == VS_LN);
            e.de  = de_m;
            e.rgb = de_m ? want : 24'h0;
            exp_q.push_back(e);
            e.rgb = de_m ? {3{8'(m_h)}} : 24'h0;
            exp0_q.push_back(e);
            if (m_h == H_TOT - 1) begin
                m_h = 0;
                m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int guard;
        rst            = 1'b1;
        rst_req        = 1'b1;
        mode           = 2'd0;
        mode_val       = 2'd0;
        bg             = 24'h102030;
        pat            = P_BOTH;
        drw.layer_en   = 2'b00;
        drw.layer_data = 48'h0;

        run(3);
        rst_req = 1'b0;
        run(3);
        de_cnt = 0;
        run(95);
        pat = P_L1;
        run(98);
        pat = P_NONE;
        run(3);
        check_eq("de_per_2frames", 32'(de_cnt), 32'd64);
        run(95);
        pat = P_RAND;
        run(98);

        // Mode requests arrive mid-frame and take effect from the next frame.
        pat = P_BOTH;
        run(40);
        mode_val = 2'd1;
        run(58 + 98);
        mode_val = 2'd2;
        run(40);
        run(58 + 98);
        mode_val = 2'd3;
        pat = P_RAND;
        run(196);
        mode_val = 2'd0;
        run(20);

        guard = 0;
        while (!(m_h == 5 && m_v == 2) && guard < 200) begin
            run(1);
            guard++;
        end
        check_eq("reach_h5_v2", 32'(guard < 200), 32'd1);
        rst_req = 1'b1;
        run(1);
        rst_req = 1'b0;
        run(2);
        check_eq("frame_cnt_after_restart", 32'(frame_cnt), 32'd1);
        run(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
